// File: rtl/fifo_rd_pkg.sv
// fifo_rd_adapter shared types and default parameters.
// Optional sequence checker is enabled with FIFO_RD_SEQCHK_EN.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

  localparam int          DSIZE_DEF    = 8;
  localparam int          CNTW_DEF     = 16;
  localparam int unsigned SEQ_INIT_DEF = 32'hA5;

endpackage

// File: rtl/fifo_rd_seqchk.sv
// Incrementing-pattern checker for words popped from the FIFO.
// Built only when FIFO_RD_SEQCHK_EN is defined.
module fifo_rd_seqchk
  import fifo_rd_pkg::*;
#(
  parameter int          DSIZE    = DSIZE_DEF,
  parameter int          CNTW     = CNTW_DEF,
  parameter int unsigned SEQ_INIT = SEQ_INIT_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cap,
  input  logic [DSIZE-1:0] i_data,
  output logic             o_seq_err,
  output logic [CNTW-1:0]  o_err_count
);

  logic             r_cap;
  logic [DSIZE-1:0] r_word;
  logic [DSIZE-1:0] r_exp;
  logic             w_bad;

  assign w_bad = r_cap && (r_word != r_exp);

  // Stage the captured word, then compare it one edge later.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cap       <= 1'b0;
      r_word      <= '0;
      r_exp       <= DSIZE'(SEQ_INIT);
      o_seq_err   <= 1'b0;
      o_err_count <= '0;
    end else begin
      r_cap     <= i_cap;
      r_word    <= i_data;
      o_seq_err <= w_bad;
      if (r_cap)
        r_exp <= r_word + DSIZE'(1);
      if (w_bad && (o_err_count != '1))
        o_err_count <= o_err_count + CNTW'(1);
    end
  end

endmodule

// File: rtl/fifo_rd_adapter.sv
// FIFO read port to registered valid/ready stream via 2-entry skid.
// Define FIFO_RD_SEQCHK_EN to build the sequence checker.
module fifo_rd_adapter
  import fifo_rd_pkg::*;
#(
  parameter int          DSIZE    = DSIZE_DEF,
  parameter int          CNTW     = CNTW_DEF,
  parameter int unsigned SEQ_INIT = SEQ_INIT_DEF
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             m_valid,
  output logic [DSIZE-1:0] m_data,
  input  logic             m_ready,
  output logic [CNTW-1:0]  pop_count,
  output logic             seq_err,
  output logic [CNTW-1:0]  err_count
);

  buf_state_e       r_state;
  logic [DSIZE-1:0] r_head;
  logic [DSIZE-1:0] r_tail;
  logic             w_push;
  logic             w_pop;

  assign w_push  = !rrst && !rempty && (r_state != TWO);
  assign w_pop   = (r_state != EMPTY) && m_ready;
  assign rinc    = w_push;
  assign m_valid = (r_state != EMPTY);
  assign m_data  = r_head;

  // Skid buffer occupancy FSM with head/tail entries.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_state <= EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_push) begin
            r_head  <= rdata;
            r_state <= ONE;
          end
        end
        ONE: begin
          case ({w_push, w_pop})
            2'b10: begin
              r_tail  <= rdata;
              r_state <= TWO;
            end
            2'b01: r_state <= EMPTY;
            2'b11: r_head  <= rdata;
            default: ;
          endcase
        end
        TWO: begin
          if (w_pop) begin
            r_head  <= r_tail;
            r_state <= ONE;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  // Count every word taken from the FIFO, wrapping.
  always_ff @(posedge rclk) begin
    if (rrst)
      pop_count <= '0;
    else if (w_push)
      pop_count <= pop_count + CNTW'(1);
  end

`ifdef FIFO_RD_SEQCHK_EN
  fifo_rd_seqchk #(
    .DSIZE    (DSIZE),
    .CNTW     (CNTW),
    .SEQ_INIT (SEQ_INIT)
  ) u_seqchk (
    .i_clk       (rclk),
    .i_rst       (rrst),
    .i_cap       (w_push),
    .i_data      (rdata),
    .o_seq_err   (seq_err),
    .o_err_count (err_count)
  );
`else
  assign seq_err   = 1'b0;
  assign err_count = '0;
`endif

endmodule
